lv2_il_fill_responder: RTL and testbench
========================================

Name: lv2_il_fill_responder

Overview:
- Level-2-side responder for instruction-fetch misses from one level-1 instruction cache over the lv1/lv2 bus.
- Accepts a granted lv2_rd request and latches the address.
- Fetches the block word through a request/acknowledge port into the level-2 array.
- Drives the word onto the lv1/lv2 data bus with data_in_bus_lv1_lv2 and holds both until the level-1 side drops lv2_rd (four-phase handshake).

Parameters:
- DATA_WID, `DATA_WID_LV1, data bus width.
- ADDR_WID, `ADDR_WID_LV1, address bus width.
- TIMEOUT_CYC, 64, maximum cycles waiting for arr_ack before abort.
- CNT_WID, 7, width of the watchdog counter; must hold TIMEOUT_CYC.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- bus_lv1_lv2_gnt_proc  input  1  lv1/lv2 bus granted to the instruction-cache requester.
- lv2_rd  input  1  read request from level-1 instruction cache.
- addr_bus_lv1_lv2  input  ADDR_WID  request address, valid while lv2_rd is high.
- data_bus_lv1_lv2  output  DATA_WID  tri-state return data; 'z when not driving.
- data_in_bus_lv1_lv2  output  1  return data valid on data_bus_lv1_lv2.
- arr_rd_req  output  1  read request to level-2 array.
- arr_addr  output  ADDR_WID  latched address to level-2 array.
- arr_ack  input  1  array read complete, single-cycle pulse.
- arr_data  input  DATA_WID  array data, valid with arr_ack.
- busy  output  1  responder not in IDLE.
- err_timeout  output  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (rst high at a clock edge), from any state:
  - state goes to IDLE; data_in_bus_lv1_lv2=0, data_bus_lv1_lv2='z, arr_rd_req=0, arr_addr=0, busy=0, err_timeout=0.
  - Watchdog counter and data latch cleared.
- States: IDLE, REQ, WAIT, DRIVE, RELEASE.
- IDLE:
  - If lv2_rd and bus_lv1_lv2_gnt_proc are both high at an edge, latch addr_bus_lv1_lv2 into arr_addr and go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - arr_rd_req=1 for exactly one cycle, then go to WAIT.
  - Watchdog cleared to 0 on entry.
- WAIT:
  - arr_rd_req=0; watchdog increments each cycle.
  - arr_ack high: capture arr_data and go to DRIVE. arr_ack in the same cycle the watchdog reaches TIMEOUT_CYC-1 counts as success.
  - Watchdog reaches TIMEOUT_CYC-1 without arr_ack: pulse err_timeout for 1 cycle and go to RELEASE; data_in_bus_lv1_lv2 is never asserted.
- DRIVE:
  - data_bus_lv1_lv2 = captured data and data_in_bus_lv1_lv2=1, both registered (first visible the cycle after arr_ack).
  - Held stable until lv2_rd samples low, then go to IDLE with data_in_bus_lv1_lv2=0 and the bus 'z from the next cycle.
- RELEASE: wait for lv2_rd low, then go to IDLE.
- Early abort: lv2_rd dropping in REQ or WAIT means the request is abandoned.
  - Go to IDLE after the array transaction completes (arr_ack or timeout).
  - No data is driven and a late arr_ack is discarded.
- Request acceptance:
  - The address is sampled only on IDLE acceptance; later changes are ignored.
  - A new request is not accepted in the same cycle the responder returns to IDLE. Minimum gap is one IDLE cycle.
- Latency: lv2_rd+grant accepted at edge N; arr_rd_req high in cycle N+1; arr_ack at edge M gives data_in_bus_lv1_lv2 high from cycle M+1.
- busy=1 in all states except IDLE.
- The responder never drives data_bus_lv1_lv2 outside DRIVE.

Test Plan:
- Basic fill:
  - Stimulus: reset, then lv2_rd=1 and gnt=1 with addr=0x0000_0040; arr_ack 3 cycles after arr_rd_req with arr_data=0xDEAD_BEEF.
  - Required: arr_rd_req is a single-cycle pulse with arr_addr=0x40; data bus=0xDEADBEEF and data_in=1 the cycle after ack; data is held until lv2_rd drops, then data_in=0 and the bus is 'z.
- No grant: lv2_rd=1, gnt=0 for 10 cycles -> arr_rd_req stays 0 and busy stays 0.
- Timeout: no arr_ack with TIMEOUT_CYC=64 -> err_timeout pulses exactly 64 cycles after arr_rd_req; data_in never asserts; return to IDLE once lv2_rd is low.
- Early abort: lv2_rd drops in WAIT, then arr_ack arrives -> data_in stays 0, the bus stays 'z, and the next request is served normally.
- Reset in DRIVE: rst pulsed while data_in=1 -> the next cycle has data_in=0, the bus 'z, busy=0, state IDLE.
- Back-to-back:
  - Stimulus: second request at addr=0x80 presented immediately after the first handshake releases.
  - Required: accepted no earlier than one IDLE cycle later, with arr_addr=0x80.

Source files
------------

// File: rtl/lv2_il_fill_responder.sv
// Level-2 responder for level-1 instruction-cache fill requests.
// The responder accepts a granted lv2_rd, fetches one word from the level-2
// array through a req/ack port, then returns it on the shared lv1/lv2 bus.
// The return uses a four-phase handshake: data is held until lv2_rd drops.
// A watchdog bounds the array wait. A request abandoned by the level-1 side
// still runs its array transaction to completion, but its result is discarded.

`ifndef DATA_WID_LV1
`define DATA_WID_LV1 32
`endif
`ifndef ADDR_WID_LV1
`define ADDR_WID_LV1 32
`endif

module lv2_il_fill_responder #(
  parameter int DATA_WID    = `DATA_WID_LV1,
  parameter int ADDR_WID    = `ADDR_WID_LV1,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_WID     = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bus_lv1_lv2_gnt_proc,
  input  logic                lv2_rd,
  input  logic [ADDR_WID-1:0] addr_bus_lv1_lv2,
  output logic [DATA_WID-1:0] data_bus_lv1_lv2,
  output logic                data_in_bus_lv1_lv2,
  output logic                arr_rd_req,
  output logic [ADDR_WID-1:0] arr_addr,
  input  logic                arr_ack,
  input  logic [DATA_WID-1:0] arr_data,
  output logic                busy,
  output logic                err_timeout
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_DRIVE   = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  // The watchdog is cleared when REQ is entered and counts on every edge
  // spent in REQ and WAIT. It therefore equals the WAIT cycle index, and the
  // abort pulse lands exactly TIMEOUT_CYC cycles after the arr_rd_req cycle.
  localparam logic [CNT_WID-1:0] WD_LAST = CNT_WID'(TIMEOUT_CYC - 1);

  logic [2:0]          state, state_nxt;
  logic [CNT_WID-1:0]  wdog;
  logic [DATA_WID-1:0] data_q;
  logic                abort_q;
  logic                abort_now;
  logic                accept;
  logic                wd_expire;

  // The level-1 side has abandoned the request if lv2_rd was low at any
  // sampled edge since acceptance, including the current one.
  assign abort_now = abort_q | ~lv2_rd;
  assign accept    = lv2_rd & bus_lv1_lv2_gnt_proc;
  assign wd_expire = (wdog == WD_LAST) & ~arr_ack;

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (accept) state_nxt = S_REQ;
      S_REQ:     state_nxt = S_WAIT;
      S_WAIT: begin
        if (arr_ack)
          state_nxt = abort_now ? S_IDLE : S_DRIVE;
        else if (wd_expire)
          state_nxt = abort_now ? S_IDLE : S_RELEASE;
      end
      S_DRIVE:   if (!lv2_rd) state_nxt = S_IDLE;
      S_RELEASE: if (!lv2_rd) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Latch the address only on acceptance, so later bus changes are ignored.
  always_ff @(posedge clk) begin
    if (rst)                           arr_addr <= '0;
    else if (state == S_IDLE && accept) arr_addr <= addr_bus_lv1_lv2;
  end

  // Watchdog: cleared on acceptance and advanced while the array is pending.
  always_ff @(posedge clk) begin
    if (rst)
      wdog <= '0;
    else if (state == S_IDLE && accept)
      wdog <= '0;
    else if ((state == S_REQ) || (state == S_WAIT && !arr_ack && !wd_expire))
      wdog <= wdog + 1'b1;
  end

  // Track abandonment; it is reset for each newly accepted request.
  always_ff @(posedge clk) begin
    if (rst)
      abort_q <= 1'b0;
    else if (state == S_IDLE)
      abort_q <= 1'b0;
    else if ((state == S_REQ || state == S_WAIT) && !lv2_rd)
      abort_q <= 1'b1;
  end

  // Capture returned array data, but only for a request that is still live.
  always_ff @(posedge clk) begin
    if (rst)
      data_q <= '0;
    else if (state == S_WAIT && arr_ack && !abort_now)
      data_q <= arr_data;
  end

  // Single-cycle timeout pulse, raised on the edge that leaves WAIT by expiry.
  always_ff @(posedge clk) begin
    if (rst) err_timeout <= 1'b0;
    else     err_timeout <= (state == S_WAIT) & wd_expire;
  end

  // The outputs are decoded from the state register, so every output changes
  // only at a clock edge. The bus floats everywhere except in DRIVE.
  assign arr_rd_req          = (state == S_REQ);
  assign busy                = (state != S_IDLE);
  assign data_in_bus_lv1_lv2 = (state == S_DRIVE);
  assign data_bus_lv1_lv2    = (state == S_DRIVE) ? data_q : {DATA_WID{1'bz}};

endmodule

// File: tb/tb_lv2_il_fill_responder.sv
// Directed bench for lv2_il_fill_responder. The bench drives inputs 1 time
// unit after each rising edge and samples the outputs at that same point.
module tb_lv2_il_fill_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        gnt;
  logic        lv2_rd;
  logic [31:0] addr;
  wire  [31:0] data_bus;
  logic        data_in;
  logic        arr_rd_req;
  logic [31:0] arr_addr;
  logic        arr_ack;
  logic [31:0] arr_data;
  logic        busy;
  logic        err_timeout;

  int total = 0;
  int bad   = 0;
  logic [31:0] zv;

  lv2_il_fill_responder #(.DATA_WID(32), .ADDR_WID(32), .TIMEOUT_CYC(64), .CNT_WID(7)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .bus_lv1_lv2_gnt_proc (gnt),
    .lv2_rd               (lv2_rd),
    .addr_bus_lv1_lv2     (addr),
    .data_bus_lv1_lv2     (data_bus),
    .data_in_bus_lv1_lv2  (data_in),
    .arr_rd_req           (arr_rd_req),
    .arr_addr             (arr_addr),
    .arr_ack              (arr_ack),
    .arr_data             (arr_data),
    .busy                 (busy),
    .err_timeout          (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    zv = 'z;
    rst = 1'b1; gnt = 1'b0; lv2_rd = 1'b0; addr = '0;
    arr_ack = 1'b0; arr_data = '0;
    tick(2);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_data_in", {31'd0, data_in}, 32'd0);
    chk("rst_arr_rd_req", {31'd0, arr_rd_req}, 32'd0);
    chk("rst_arr_addr", arr_addr, 32'd0);
    chk("rst_err", {31'd0, err_timeout}, 32'd0);
    chk("rst_bus_z", data_bus, zv);
    rst = 1'b0;
    tick(1);

    // Basic fill: ack three cycles after the request cycle.
    lv2_rd = 1'b1; gnt = 1'b1; addr = 32'h0000_0040;
    tick(1);
    chk("fill_req", {31'd0, arr_rd_req}, 32'd1);
    chk("fill_addr", arr_addr, 32'h40);
    chk("fill_busy", {31'd0, busy}, 32'd1);
    addr = 32'h0000_1234; gnt = 1'b0;
    tick(1);
    chk("fill_req_pulse", {31'd0, arr_rd_req}, 32'd0);
    chk("fill_addr_held", arr_addr, 32'h40);
    tick(1);
    chk("fill_no_data_yet", {31'd0, data_in}, 32'd0);
    tick(1);
    arr_ack = 1'b1; arr_data = 32'hDEAD_BEEF;
    chk("fill_data_in_at_ack", {31'd0, data_in}, 32'd0);
    tick(1);
    arr_ack = 1'b0; arr_data = 32'h0;
    chk("fill_data_in", {31'd0, data_in}, 32'd1);
    chk("fill_bus", data_bus, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("fill_hold_data_in", {31'd0, data_in}, 32'd1);
      chk("fill_hold_bus", data_bus, 32'hDEAD_BEEF);
    end
    lv2_rd = 1'b0;
    tick(1);
    chk("fill_rel_data_in", {31'd0, data_in}, 32'd0);
    chk("fill_rel_bus_z", data_bus, zv);
    chk("fill_rel_busy", {31'd0, busy}, 32'd0);

    // No grant: the request is never accepted.
    lv2_rd = 1'b1; gnt = 1'b0; addr = 32'h0000_0999;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("nogrant_req", {31'd0, arr_rd_req}, 32'd0);
      chk("nogrant_busy", {31'd0, busy}, 32'd0);
    end
    lv2_rd = 1'b0;
    tick(1);

    // Back-to-back: lv2_rd low for exactly one edge, then a request at 0x80.
    lv2_rd = 1'b1; gnt = 1'b1; addr = 32'h0000_0100;
    tick(1);
    chk("b2b_first_addr", arr_addr, 32'h100);
    tick(1);
    arr_ack = 1'b1; arr_data = 32'h1111_2222;
    tick(1);
    arr_ack = 1'b0;
    chk("b2b_first_bus", data_bus, 32'h1111_2222);
    lv2_rd = 1'b0;
    tick(1);
    lv2_rd = 1'b1; addr = 32'h0000_0080;
    chk("b2b_gap_busy", {31'd0, busy}, 32'd0);
    chk("b2b_gap_req", {31'd0, arr_rd_req}, 32'd0);
    tick(1);
    chk("b2b_second_req", {31'd0, arr_rd_req}, 32'd1);
    chk("b2b_second_addr", arr_addr, 32'h80);
    tick(1);
    arr_ack = 1'b1; arr_data = 32'h8080_0000;
    tick(1);
    arr_ack = 1'b0;
    chk("b2b_second_bus", data_bus, 32'h8080_0000);
    lv2_rd = 1'b0;
    tick(1);

    // Timeout: err_timeout exactly 64 cycles after the arr_rd_req cycle.
    lv2_rd = 1'b1; gnt = 1'b1; addr = 32'h0000_0200;
    tick(1);
    chk("to_req", {31'd0, arr_rd_req}, 32'd1);
    for (int k = 1; k < 64; k++) begin
      tick(1);
      chk("to_err_early", {31'd0, err_timeout}, 32'd0);
      chk("to_data_in", {31'd0, data_in}, 32'd0);
    end
    tick(1);
    chk("to_err_pulse", {31'd0, err_timeout}, 32'd1);
    chk("to_data_in_end", {31'd0, data_in}, 32'd0);
    chk("to_busy", {31'd0, busy}, 32'd1);
    tick(1);
    chk("to_err_single", {31'd0, err_timeout}, 32'd0);
    tick(1);
    chk("to_release_busy", {31'd0, busy}, 32'd1);
    chk("to_release_bus_z", data_bus, zv);
    lv2_rd = 1'b0;
    tick(1);
    chk("to_idle_busy", {31'd0, busy}, 32'd0);

    // Ack on the last watchdog cycle still counts as success.
    lv2_rd = 1'b1; addr = 32'h0000_0300;
    tick(1);
    for (int k = 1; k < 63; k++) tick(1);
    tick(1);
    arr_ack = 1'b1; arr_data = 32'hCAFE_F00D;
    chk("edge_ack_err", {31'd0, err_timeout}, 32'd0);
    tick(1);
    arr_ack = 1'b0;
    chk("edge_ack_err_after", {31'd0, err_timeout}, 32'd0);
    chk("edge_ack_data_in", {31'd0, data_in}, 32'd1);
    chk("edge_ack_bus", data_bus, 32'hCAFE_F00D);
    lv2_rd = 1'b0;
    tick(1);

    // Early abort: lv2_rd drops in WAIT and the late ack is discarded.
    lv2_rd = 1'b1; addr = 32'h0000_0400;
    tick(1);
    tick(1);
    lv2_rd = 1'b0;
    tick(1);
    chk("abort_busy_wait", {31'd0, busy}, 32'd1);
    tick(1);
    arr_ack = 1'b1; arr_data = 32'h5555_AAAA;
    tick(1);
    arr_ack = 1'b0;
    chk("abort_data_in", {31'd0, data_in}, 32'd0);
    chk("abort_bus_z", data_bus, zv);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    tick(1);
    chk("abort_data_in_2", {31'd0, data_in}, 32'd0);
    lv2_rd = 1'b1; addr = 32'h0000_0440;
    tick(1);
    chk("abort_next_addr", arr_addr, 32'h440);
    tick(1);
    arr_ack = 1'b1; arr_data = 32'h1234_5678;
    tick(1);
    arr_ack = 1'b0;
    chk("abort_next_data_in", {31'd0, data_in}, 32'd1);
    chk("abort_next_bus", data_bus, 32'h1234_5678);
    lv2_rd = 1'b0;
    tick(1);

    // Reset while driving.
    lv2_rd = 1'b1; addr = 32'h0000_0500;
    tick(1);
    tick(1);
    arr_ack = 1'b1; arr_data = 32'h0BAD_CAFE;
    tick(1);
    arr_ack = 1'b0;
    chk("rstd_data_in_before", {31'd0, data_in}, 32'd1);
    rst = 1'b1; lv2_rd = 1'b0;
    tick(1);
    chk("rstd_data_in", {31'd0, data_in}, 32'd0);
    chk("rstd_bus_z", data_bus, zv);
    chk("rstd_busy", {31'd0, busy}, 32'd0);
    chk("rstd_arr_addr", arr_addr, 32'd0);
    rst = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
